seqdet_ctrl: RTL and testbench
==============================

SEQDET_CTRL -- requirements
Module: seqdet_ctrl

Interface
REQ-001 Parameter PAT_W, default 8, max pattern length in bits.
REQ-002 Parameter CNT_W, default 8, match counter width.
REQ-003 Parameter TMO_CYC, default 1000, idle-cycle timeout limit (used only when SEQDET_TIMEOUT_EN defined).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 cfg_valid  input  1  configuration offer.
REQ-007 cfg_ready  output  1  configuration accepted when cfg_valid && cfg_ready.
REQ-008 cfg_pattern  input  PAT_W  pattern; bit 0 = last serial bit of sequence.
REQ-009 cfg_len  input  $clog2(PAT_W)+1  pattern length in bits.
REQ-010 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 cfg_target  input  CNT_W  matches required for done; 0 = unlimited.
REQ-012 start  input  1  arm detector.
REQ-013 abort  input  1  return to IDLE.
REQ-014 din_valid  input  1  serial bit qualifier.
REQ-015 din  input  1  serial data bit.
REQ-016 busy  output  1  high in ARMED.
REQ-017 hit  output  1  one-cycle match pulse.
REQ-018 match_cnt  output  CNT_W  matches since last start.
REQ-019 done  output  1  one-cycle target-reached pulse.
REQ-020 timeout  output  1  one-cycle timeout pulse; tied 0 without SEQDET_TIMEOUT_EN.

Function
REQ-021 FSM states IDLE, ARMED, DONE; all outputs registered (Moore).
REQ-022 cfg_ready SHALL be 1 only in IDLE; accepted fields are stored in shadow registers.
REQ-023 IDLE + start -> ARMED only if stored len is 1..PAT_W; otherwise start is ignored.
REQ-024 cfg_valid and start in the same IDLE cycle: configuration captured, start ignored.
REQ-025 On entry to ARMED: history register, bit count and match_cnt cleared.
REQ-026 In ARMED, each din_valid cycle shifts din into history LSB; bit count saturates at len.
REQ-027 Match when bit count >= len (including current bit) and the low len history bits equal the low len pattern bits.
REQ-028 hit SHALL assert exactly one cycle after the clk edge that samples the matching bit.
REQ-029 Overlap mode: history retained after match; non-overlap: bit count cleared to 0 on match.
REQ-030 match_cnt increments per match, saturating at 2^CNT_W-1.
REQ-031 When match_cnt reaches nonzero cfg_target: ARMED -> DONE; done=1 for one cycle in DONE; DONE -> IDLE unconditionally.
REQ-032 abort in ARMED or DONE -> IDLE next cycle; abort wins over a same-cycle match (no hit, no increment); match_cnt holds its value.
REQ-033 Cycles with din_valid=0 leave history, count and outputs (except pulses) unchanged.

Reset
REQ-034 reset SHALL force IDLE, cfg_ready=1, busy=0, hit=0, done=0, timeout=0, match_cnt=0, history=0, shadow pattern/len/overlap/target = 0.
REQ-035 reset mid-ARMED discards all in-flight history with no hit or done pulse.

Configuration
REQ-036 SEQDET_TIMEOUT_EN defined: counter in ARMED counts cycles since arming or last match; at TMO_CYC -> IDLE with timeout=1 for one cycle; a match in the same cycle wins and restarts the count.
REQ-037 SEQDET_TIMEOUT_EN undefined: no counter logic; timeout constant 0; ARMED leaves only via target, abort or reset.

Structure
REQ-038 Shared package seqdet_pkg SHALL hold the state enum (IDLE/ARMED/DONE encodings) and the default PAT_W/CNT_W constants.
REQ-039 Sub-module seqdet_core SHALL hold history shift register, bit count and match compare; seqdet_ctrl holds FSM, shadow config, counters.

Verification
REQ-040 pattern=1001, len=4, overlap=0, target=0, din=1001001 -> one hit, one cycle after bit 4; match_cnt=1.
REQ-041 Same stimulus with overlap=1 -> two hits (after bits 4 and 7); match_cnt=2.
REQ-042 target=2, overlap=1, din=1001001 -> done pulse cycle after second hit; FSM back in IDLE, cfg_ready=1.
REQ-043 abort asserted on cycle sampling bit 4 of 1001 -> no hit, match_cnt=0, IDLE next cycle.
REQ-044 CNT_W=2, pattern=1, len=1, target=0, din=1 for 5 bits -> match_cnt saturates at 3, five hits.
REQ-045 SEQDET_TIMEOUT_EN, TMO_CYC=10, armed, din_valid=0 -> timeout pulse at cycle 10, IDLE; without macro stays ARMED.

Source files
------------

// File: rtl/seqdet_pkg.sv
// Shared state encoding, default widths and length-field sizing for the serial pattern detector.
package seqdet_pkg;
    localparam int PAT_W_DEF = 8;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Length field must hold the value PAT_W itself, hence the extra bit.
    function automatic int len_w(input int pat_w);
        return $clog2(pat_w) + 1;
    endfunction
endpackage

// File: rtl/seqdet_if.sv
// Configuration, control, serial data and status bundle for the pattern detector.
// master = requester driving config/data, slave = detector.
interface seqdet_if #(
    parameter int PAT_W = seqdet_pkg::PAT_W_DEF,
    parameter int CNT_W = seqdet_pkg::CNT_W_DEF
);
    import seqdet_pkg::*;
    localparam int LEN_W = len_w(PAT_W);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
    logic             start;
    logic             abort;
    logic             din_valid;
    logic             din;
    logic             busy;
    logic             hit;
    logic [CNT_W-1:0] match_cnt;
    logic             done;
    logic             timeout;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        output start, abort, din_valid, din,
        input  cfg_ready, busy, hit, match_cnt, done, timeout
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        input  start, abort, din_valid, din,
        output cfg_ready, busy, hit, match_cnt, done, timeout
    );
endinterface

// File: rtl/seqdet_core.sv
// History shift register, saturating bit count and pattern compare; match is combinational on the bit being shifted.
// Latency 0 (match flags the current shift); no backpressure, shifts on every cycle with shift=1.
module seqdet_core #(
    parameter int  PAT_W = seqdet_pkg::PAT_W_DEF,
    localparam int LEN_W = seqdet_pkg::len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift,
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             overlap,
    output logic             match
);
    import seqdet_pkg::*;

    logic [PAT_W-1:0] history;
    logic [PAT_W-1:0] hist_next;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] bit_cnt;
    logic [LEN_W-1:0] cnt_inc;

    always_comb begin
        hist_next = (history << 1) | PAT_W'(din);
        cnt_inc   = (bit_cnt >= len) ? len : bit_cnt + 1'b1;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        match = (cnt_inc == len) && (((hist_next ^ pattern) & mask) == '0);
    end

    // Non-overlap restarts the count only; stale history is masked by the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            history <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            history <= '0;
            bit_cnt <= '0;
        end else if (shift) begin
            history <= hist_next;
            bit_cnt <= (match && !overlap) ? '0 : cnt_inc;
        end
    end
endmodule

// File: rtl/seqdet_ctrl.sv
// Serial pattern detector control: FSM, shadow config, match counter; hit/done one cycle after the sampling edge.
// cfg accepted only in IDLE (cfg_ready); din is never stalled. SEQDET_TIMEOUT_EN adds the idle-cycle timeout.
module seqdet_ctrl #(
    parameter int  PAT_W   = seqdet_pkg::PAT_W_DEF,
    parameter int  CNT_W   = seqdet_pkg::CNT_W_DEF,
    parameter int  TMO_CYC = 1000,
    localparam int LEN_W   = seqdet_pkg::len_w(PAT_W)
) (
    input logic     clk,
    input logic     reset,
    seqdet_if.slave bus
);
    import seqdet_pkg::*;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    state_t           state, state_nxt;
    logic [PAT_W-1:0] sh_pattern;
    logic [LEN_W-1:0] sh_len;
    logic             sh_overlap;
    logic [CNT_W-1:0] sh_target;
    logic [CNT_W-1:0] cnt_q;
    logic             hit_q;
    logic             cfg_take, len_ok, arm, reached, proc, shift, core_match, hit_now;

    assign cfg_take = bus.cfg_valid && (state == IDLE);
    assign len_ok   = (sh_len != '0) && (sh_len <= LEN_MAX);
    assign arm      = (state == IDLE) && bus.start && !bus.cfg_valid && len_ok;
    assign reached  = (sh_target != '0) && (cnt_q == sh_target);
    // Once the target is reached the next cycle only moves to DONE; no further bits are consumed.
    assign proc     = (state == ARMED) && !bus.abort && !reached;
    assign shift    = proc && bus.din_valid;
    assign hit_now  = shift && core_match;

    seqdet_core #(.PAT_W(PAT_W)) u_core (
        .clk     (clk),
        .reset   (reset),
        .clear   (arm),
        .shift   (shift),
        .din     (bus.din),
        .pattern (sh_pattern),
        .len     (sh_len),
        .overlap (sh_overlap),
        .match   (core_match)
    );

`ifdef SEQDET_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_fire;
    logic             timeout_q;

    assign tmo_fire = proc && !hit_now && (tmo_cnt == TMO_W'(TMO_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= tmo_fire;
            if (arm || hit_now) tmo_cnt <= '0;
            else if (state == ARMED) tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign bus.timeout = timeout_q;
`else
    // TMO_CYC has no role in this build; the output folds to constant 0.
    assign bus.timeout = (TMO_CYC < 0);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (arm) state_nxt = ARMED;
            end
            ARMED: begin
                if (bus.abort) state_nxt = IDLE;
                else if (reached) state_nxt = DONE;
`ifdef SEQDET_TIMEOUT_EN
                else if (tmo_fire) state_nxt = IDLE;
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_pattern <= '0;
            sh_len     <= '0;
            sh_overlap <= 1'b0;
            sh_target  <= '0;
        end else if (cfg_take) begin
            sh_pattern <= bus.cfg_pattern;
            sh_len     <= bus.cfg_len;
            sh_overlap <= bus.cfg_overlap;
            sh_target  <= bus.cfg_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_now;
            if (arm) cnt_q <= '0;
            else if (hit_now && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.cfg_ready = (state == IDLE);
    assign bus.busy      = (state == ARMED);
    assign bus.done      = (state == DONE);
    assign bus.hit       = hit_q;
    assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_seqdet_ctrl.sv
// Bench for seqdet_ctrl: directed vector table, hand-written corner sequences, randomized run against a queue-based model.
module tb_seqdet_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seqdet_if #(.PAT_W(8), .CNT_W(8)) bus_a ();
    seqdet_if #(.PAT_W(8), .CNT_W(2)) bus_b ();

    seqdet_ctrl #(.PAT_W(8), .CNT_W(8), .TMO_CYC(10)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    seqdet_ctrl #(.PAT_W(8), .CNT_W(2), .TMO_CYC(10)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string       name;
        bit          cv;
        logic [7:0]  pat;
        logic [3:0]  len;
        bit          ovl;
        logic [7:0]  tgt;
        bit          st, ab, dv, d;
        logic [31:0] exp;
    } vec_t;

    logic [7:0] cur_pat;
    logic [3:0] cur_len;
    bit         cur_ovl;
    logic [7:0] cur_tgt;

    localparam int M_IDLE = 0, M_ARMED = 1, M_DONE = 2;
    int         m_mode, m_cnt, m_since, s_len, s_tgt;
    bit         m_q[$];
    bit         m_hit, m_to, s_ovl;
    logic [7:0] s_pat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] pack(bit rdy, bit busy, bit hit, bit done, bit tmo, logic [7:0] cnt);
        return {19'd0, rdy, busy, hit, done, tmo, cnt};
    endfunction

    function automatic logic [31:0] obs_a();
        return {19'd0, bus_a.cfg_ready, bus_a.busy, bus_a.hit, bus_a.done, bus_a.timeout, bus_a.match_cnt};
    endfunction

    function automatic vec_t mk(string n, bit cv, bit st, bit ab, bit dv, bit d,
                                bit rdy, bit busy, bit hit, bit done, int cnt);
        vec_t v;
        v.name = n; v.cv = cv; v.pat = cur_pat; v.len = cur_len; v.ovl = cur_ovl; v.tgt = cur_tgt;
        v.st = st; v.ab = ab; v.dv = dv; v.d = d;
        v.exp = pack(rdy, busy, hit, done, 1'b0, 8'(cnt));
        return v;
    endfunction

    task automatic drive_a(bit cv, logic [7:0] pat, logic [3:0] len, bit ovl, logic [7:0] tgt,
                           bit st, bit ab, bit dv, bit d);
        bus_a.cfg_valid = cv;  bus_a.cfg_pattern = pat; bus_a.cfg_len = len;
        bus_a.cfg_overlap = ovl; bus_a.cfg_target = tgt;
        bus_a.start = st; bus_a.abort = ab; bus_a.din_valid = dv; bus_a.din = d;
    endtask

    // Reference: bits since arming (or since last non-overlapping match) kept in a queue;
    // a match is the queue tail equal to the pattern's low len bits.
    function automatic bit tail_match();
        if (m_q.size() < s_len) return 1'b0;
        for (int k = 0; k < s_len; k++)
            if (m_q[m_q.size() - 1 - k] != s_pat[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_cnt = 0; m_since = 0; m_hit = 0; m_to = 0;
        m_q.delete();
        s_pat = '0; s_len = 0; s_ovl = 0; s_tgt = 0;
    endtask

    task automatic model_step(bit cv, logic [7:0] pat, logic [3:0] len, bit ovl, logic [7:0] tgt,
                              bit st, bit ab, bit dv, bit d);
        m_hit = 0; m_to = 0;
        case (m_mode)
            M_IDLE: begin
                if (cv) begin
                    s_pat = pat; s_len = int'(len); s_ovl = ovl; s_tgt = int'(tgt);
                end else if (st && s_len >= 1 && s_len <= 8) begin
                    m_mode = M_ARMED; m_q.delete(); m_cnt = 0; m_since = 0;
                end
            end
            M_ARMED: begin
                if (ab) m_mode = M_IDLE;
                else if (s_tgt != 0 && m_cnt == s_tgt) m_mode = M_DONE;
                else begin
                    if (dv) begin
                        m_q.push_back(d);
                        if (tail_match()) begin
                            m_hit = 1;
                            if (m_cnt < 255) m_cnt++;
                            if (!s_ovl) m_q.delete();
                        end
                        if (m_q.size() > 8) void'(m_q.pop_front());
                    end
`ifdef SEQDET_TIMEOUT_EN
                    if (m_hit) m_since = 0;
                    else begin
                        m_since++;
                        if (m_since == 10) begin m_mode = M_IDLE; m_to = 1; end
                    end
`endif
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1);
    end

    initial begin
        vec_t       vt[$];
        logic [6:0] s7;
        logic [7:0] s8;
        logic [31:0] exp_v;
        bit         r_cv, r_ovl, r_st, r_ab, r_dv, r_d;
        logic [7:0] r_pat, r_tgt;
        logic [3:0] r_len;

        drive_a(0, 8'd0, 4'd0, 0, 8'd0, 0, 0, 0, 0);
        bus_b.cfg_valid = 0; bus_b.cfg_pattern = '0; bus_b.cfg_len = '0; bus_b.cfg_overlap = 0;
        bus_b.cfg_target = '0; bus_b.start = 0; bus_b.abort = 0; bus_b.din_valid = 0; bus_b.din = 0;

        repeat (2) @(posedge clk);
        #1 check("reset_state", obs_a(), pack(1, 0, 0, 0, 0, 8'd0));
        @(negedge clk) reset = 1'b0;

        // ---------- directed vector table ----------
        s7 = 7'b1001001;
        cur_pat = 8'b1001; cur_len = 4; cur_ovl = 0; cur_tgt = 0;
        vt.push_back(mk("A_cfg",   1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk("A_start", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 7; i++)
            vt.push_back(mk("A_bit", 0, 0, 0, 1, s7[6-i], 0, 1, (i == 3), 0, (i >= 3) ? 1 : 0));
        vt.push_back(mk("A_abort", 0, 0, 1, 0, 0, 1, 0, 0, 0, 1));

        cur_ovl = 1;
        vt.push_back(mk("B_cfg",   1, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        vt.push_back(mk("B_start", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 7; i++) begin
            if (i == 5) vt.push_back(mk("B_gap", 0, 0, 0, 0, 1, 0, 1, 0, 0, 1));
            vt.push_back(mk("B_bit", 0, 0, 0, 1, s7[6-i], 0, 1, (i == 3 || i == 6), 0,
                            (i >= 6) ? 2 : ((i >= 3) ? 1 : 0)));
        end
        vt.push_back(mk("B_abort", 0, 0, 1, 0, 0, 1, 0, 0, 0, 2));

        cur_tgt = 2;
        vt.push_back(mk("C_cfg",   1, 0, 0, 0, 0, 1, 0, 0, 0, 2));
        vt.push_back(mk("C_start", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 7; i++)
            vt.push_back(mk("C_bit", 0, 0, 0, 1, s7[6-i], 0, 1, (i == 3 || i == 6), 0,
                            (i >= 6) ? 2 : ((i >= 3) ? 1 : 0)));
        vt.push_back(mk("C_done", 0, 0, 0, 1, 1, 0, 0, 0, 1, 2));
        vt.push_back(mk("C_idle", 0, 0, 0, 1, 1, 1, 0, 0, 0, 2));

        cur_tgt = 0; cur_ovl = 0;
        vt.push_back(mk("D_cfg",   1, 0, 0, 0, 0, 1, 0, 0, 0, 2));
        vt.push_back(mk("D_start", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk("D_bit", 0, 0, 0, 1, s7[6-i], 0, 1, 0, 0, 0));
        vt.push_back(mk("D_abort_on_match", 0, 0, 1, 1, 1, 1, 0, 0, 0, 0));
        vt.push_back(mk("D_after_abort",    0, 0, 0, 1, 1, 1, 0, 0, 0, 0));

        vt.push_back(mk("E_cfg_and_start", 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        cur_len = 0;
        vt.push_back(mk("E_len0_cfg",   1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk("E_len0_start", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        cur_len = 9;
        vt.push_back(mk("E_len9_cfg",   1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk("E_len9_start", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        cur_len = 8; cur_pat = 8'hA5; s8 = 8'hA5;
        vt.push_back(mk("E_len8_cfg",   1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk("E_len8_start", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            vt.push_back(mk("E_len8_bit", 0, 0, 0, 1, s8[7-i], 0, 1, (i == 7), 0, (i == 7) ? 1 : 0));
        vt.push_back(mk("E_abort", 0, 0, 1, 0, 0, 1, 0, 0, 0, 1));

        foreach (vt[i]) begin
            @(negedge clk);
            drive_a(vt[i].cv, vt[i].pat, vt[i].len, vt[i].ovl, vt[i].tgt,
                    vt[i].st, vt[i].ab, vt[i].dv, vt[i].d);
            @(posedge clk);
            #1 check(vt[i].name, obs_a(), vt[i].exp);
        end
        @(negedge clk) drive_a(0, 8'd0, 4'd0, 0, 8'd0, 0, 0, 0, 0);

        // ---------- counter saturation, CNT_W=2 ----------
        bus_b.cfg_valid = 1; bus_b.cfg_pattern = 8'd1; bus_b.cfg_len = 4'd1; bus_b.cfg_target = 2'd0;
        @(negedge clk) begin bus_b.cfg_valid = 0; bus_b.start = 1; end
        @(negedge clk) begin bus_b.start = 0; bus_b.din_valid = 1; bus_b.din = 1; end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("sat_hit", 32'(bus_b.hit), 32'd1);
            check("sat_cnt", 32'(bus_b.match_cnt), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
            @(negedge clk);
        end
        bus_b.din_valid = 0; bus_b.abort = 1;
        @(negedge clk) bus_b.abort = 0;

        // ---------- reset while armed ----------
        drive_a(1, 8'b1001, 4'd4, 0, 8'd0, 0, 0, 0, 0);
        @(negedge clk) drive_a(0, 8'b1001, 4'd4, 0, 8'd0, 1, 0, 0, 0);
        s7 = 7'b1001001;
        for (int i = 0; i < 3; i++) @(negedge clk) drive_a(0, 8'b1001, 4'd4, 0, 8'd0, 0, 0, 1, s7[6-i]);
        @(negedge clk) begin
            drive_a(0, 8'b1001, 4'd4, 0, 8'd0, 0, 0, 1, 1);
            reset = 1'b1;
        end
        #1 check("reset_mid_armed", obs_a(), pack(1, 0, 0, 0, 0, 8'd0));
        @(posedge clk);
        #1 check("reset_held", obs_a(), pack(1, 0, 0, 0, 0, 8'd0));
        @(negedge clk) begin reset = 1'b0; drive_a(0, 8'd0, 4'd0, 0, 8'd0, 1, 0, 1, 1); end
        @(posedge clk);
        #1 check("start_after_reset_ignored", obs_a(), pack(1, 0, 0, 0, 0, 8'd0));

        // ---------- idle timeout ----------
        @(negedge clk) drive_a(1, 8'b1001, 4'd4, 0, 8'd0, 0, 0, 0, 0);
        @(negedge clk) drive_a(0, 8'b1001, 4'd4, 0, 8'd0, 1, 0, 0, 0);
        @(negedge clk) drive_a(0, 8'b1001, 4'd4, 0, 8'd0, 0, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
`ifdef SEQDET_TIMEOUT_EN
            if (k < 10)       exp_v = pack(0, 1, 0, 0, 0, 8'd0);
            else if (k == 10) exp_v = pack(1, 0, 0, 0, 1, 8'd0);
            else              exp_v = pack(1, 0, 0, 0, 0, 8'd0);
`else
            exp_v = pack(0, 1, 0, 0, 0, 8'd0);
`endif
            #1 check("timeout_window", obs_a(), exp_v);
        end
        @(negedge clk) drive_a(0, 8'd0, 4'd0, 0, 8'd0, 0, 1, 0, 0);
        @(negedge clk) begin drive_a(0, 8'd0, 4'd0, 0, 8'd0, 0, 0, 0, 0); reset = 1'b1; end
        @(negedge clk) reset = 1'b0;

        // ---------- randomized run against the model ----------
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r_cv  = ($urandom_range(0, 7) == 0);
            r_pat = 8'($urandom);
            r_len = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(0, 9));
            r_ovl = 1'($urandom);
            r_tgt = 8'($urandom_range(0, 4));
            r_st  = ($urandom_range(0, 3) == 0);
            r_ab  = ($urandom_range(0, 31) == 0);
            r_dv  = ($urandom_range(0, 3) != 0);
            r_d   = 1'($urandom);
            drive_a(r_cv, r_pat, r_len, r_ovl, r_tgt, r_st, r_ab, r_dv, r_d);
            model_step(r_cv, r_pat, r_len, r_ovl, r_tgt, r_st, r_ab, r_dv, r_d);
            @(posedge clk);
            #1 check("random", obs_a(),
                     pack(m_mode == M_IDLE, m_mode == M_ARMED, m_hit, m_mode == M_DONE, m_to, 8'(m_cnt)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
